// File: rtl/perf_counter_uart.sv
// Event-counter bank with a UART reporter: counts per-channel strobes and, on request,
// streams a snapshot as HEADER, counters LSB-first, then an XOR checksum over 8N1 serial.
module perf_counter_uart #(
    parameter int         N_CH     = 8,
    parameter int         CNT_W    = 32,
    parameter int         BAUD_DIV = 868,
    parameter int         SATURATE = 1,
    parameter logic [7:0] HEADER   = 8'hA5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enb,
    input  logic [N_CH-1:0] event_i,
    input  logic            clear_i,
    input  logic            dump_i,
    output logic            busy_o,
    output logic            dump_done_o,
    output logic [N_CH-1:0] overflow_o,
    output logic            tx_o
);

    localparam int NBYTES = 2 + N_CH * CNT_W / 8;
    localparam int SHW    = N_CH * CNT_W;
    localparam int BYTE_W = $clog2(NBYTES);
    localparam int BAUD_W = $clog2(BAUD_DIV);

    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NBYTES - 1);
    localparam logic [BYTE_W-1:0] CHK_PREV  = BYTE_W'(NBYTES - 2);
    localparam logic [BAUD_W-1:0] LAST_BAUD = BAUD_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    localparam logic [1:0] F_IDLE  = 2'd0;
    localparam logic [1:0] F_SEND  = 2'd1;
    localparam logic [1:0] F_DONE  = 2'd2;

    localparam logic [1:0] U_IDLE  = 2'd0;
    localparam logic [1:0] U_START = 2'd1;
    localparam logic [1:0] U_DATA  = 2'd2;
    localparam logic [1:0] U_STOP  = 2'd3;

    logic [CNT_W-1:0]  r_cnt [N_CH];
    logic [N_CH-1:0]   r_ovf;
    logic [SHW-1:0]    w_cntFlat;
    logic [SHW-1:0]    r_shadow;
    logic [7:0]        r_chk;
    logic [7:0]        r_txByte;
    logic [1:0]        r_frameState;
    logic [1:0]        r_uartState;
    logic [BAUD_W-1:0] r_baudCnt;
    logic [2:0]        r_bitIdx;
    logic [BYTE_W-1:0] r_byteIdx;
    logic              r_tx;
    logic              r_busy;
    logic              r_done;

    always_comb begin
        w_cntFlat = '0;
        for (int k = 0; k < N_CH; k++) begin
            w_cntFlat[k*CNT_W +: CNT_W] = r_cnt[k];
        end
    end

    // Clear wins over counting; overflow flags stick until clear or reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_CH; k++) begin
                r_cnt[k] <= '0;
            end
            r_ovf <= '0;
        end else if (clear_i) begin
            for (int k = 0; k < N_CH; k++) begin
                r_cnt[k] <= '0;
            end
            r_ovf <= '0;
        end else if (enb) begin
            for (int k = 0; k < N_CH; k++) begin
                if (event_i[k]) begin
                    if (r_cnt[k] == CNT_MAX) begin
                        r_ovf[k] <= 1'b1;
                        r_cnt[k] <= (SATURATE != 0) ? CNT_MAX : '0;
                    end else begin
                        r_cnt[k] <= r_cnt[k] + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Payload bytes are peeled off the shadow LSB-first; the checksum accumulates as they go.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frameState <= F_IDLE;
            r_uartState  <= U_IDLE;
            r_baudCnt    <= '0;
            r_bitIdx     <= '0;
            r_byteIdx    <= '0;
            r_txByte     <= '0;
            r_shadow     <= '0;
            r_chk        <= '0;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_frameState)
                F_SEND: begin
                    if (r_baudCnt != LAST_BAUD) begin
                        r_baudCnt <= r_baudCnt + BAUD_W'(1);
                    end else begin
                        r_baudCnt <= '0;
                        case (r_uartState)
                            U_START: begin
                                r_uartState <= U_DATA;
                                r_bitIdx    <= '0;
                                r_tx        <= r_txByte[0];
                            end
                            U_DATA: begin
                                if (r_bitIdx == 3'd7) begin
                                    r_uartState <= U_STOP;
                                    r_tx        <= 1'b1;
                                end else begin
                                    r_bitIdx <= r_bitIdx + 3'd1;
                                    r_txByte <= {1'b0, r_txByte[7:1]};
                                    r_tx     <= r_txByte[1];
                                end
                            end
                            U_STOP: begin
                                if (r_byteIdx == LAST_BYTE) begin
                                    r_uartState  <= U_IDLE;
                                    r_frameState <= F_DONE;
                                    r_busy       <= 1'b0;
                                    r_done       <= 1'b1;
                                end else begin
                                    r_uartState <= U_START;
                                    r_tx        <= 1'b0;
                                    r_byteIdx   <= r_byteIdx + BYTE_W'(1);
                                    if (r_byteIdx == CHK_PREV) begin
                                        r_txByte <= r_chk;
                                    end else begin
                                        r_txByte <= r_shadow[7:0];
                                        r_chk    <= r_chk ^ r_shadow[7:0];
                                        r_shadow <= r_shadow >> 8;
                                    end
                                end
                            end
                            default: r_uartState <= U_IDLE;
                        endcase
                    end
                end
                default: begin
                    r_frameState <= F_IDLE;
                    if (dump_i) begin
                        r_frameState <= F_SEND;
                        r_uartState  <= U_START;
                        r_baudCnt    <= '0;
                        r_byteIdx    <= '0;
                        r_txByte     <= HEADER;
                        r_shadow     <= w_cntFlat;
                        r_chk        <= '0;
                        r_tx         <= 1'b0;
                        r_busy       <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign busy_o      = r_busy;
    assign dump_done_o = r_done;
    assign overflow_o  = r_ovf;
    assign tx_o        = r_tx;

endmodule

// File: tb/tb_perf_counter_uart.sv
// Bench for perf_counter_uart: three instances (16-bit saturate, 8-bit saturate, 8-bit wrap)
// share stimulus and are checked against a count/frame model built from the counting rules.
module tb_perf_counter_uart;

    localparam int NCH  = 2;
    localparam int BD   = 4;
    localparam int NCAP = 248;

    logic       clk = 1'b0;
    logic       rst;
    logic       enb;
    logic [1:0] eventI;
    logic       clearI;
    logic [2:0] dumpVec;

    logic       wTx   [3];
    logic       wBusy [3];
    logic       wDone [3];
    logic [1:0] wOvf  [3];

    int checkCount = 0;
    int failCount  = 0;
    int rejectTest = 0;

    int cfgW   [3] = '{16, 8, 8};
    int cfgSat [3] = '{1, 1, 0};

    longint unsigned mCnt  [3][2];
    longint unsigned mSnap [3][2];
    logic [1:0]      mOvf  [3];

    logic txS   [3][NCAP];
    logic busyS [3][NCAP];
    logic doneS [3][NCAP];

    perf_counter_uart #(.N_CH(2), .CNT_W(16), .BAUD_DIV(BD), .SATURATE(1), .HEADER(8'hA5)) uMain (
        .clk(clk), .rst(rst), .enb(enb), .event_i(eventI), .clear_i(clearI), .dump_i(dumpVec[0]),
        .busy_o(wBusy[0]), .dump_done_o(wDone[0]), .overflow_o(wOvf[0]), .tx_o(wTx[0]));

    perf_counter_uart #(.N_CH(2), .CNT_W(8), .BAUD_DIV(BD), .SATURATE(1), .HEADER(8'hA5)) uSat8 (
        .clk(clk), .rst(rst), .enb(enb), .event_i(eventI), .clear_i(clearI), .dump_i(dumpVec[1]),
        .busy_o(wBusy[1]), .dump_done_o(wDone[1]), .overflow_o(wOvf[1]), .tx_o(wTx[1]));

    perf_counter_uart #(.N_CH(2), .CNT_W(8), .BAUD_DIV(BD), .SATURATE(0), .HEADER(8'hA5)) uWrap8 (
        .clk(clk), .rst(rst), .enb(enb), .event_i(eventI), .clear_i(clearI), .dump_i(dumpVec[2]),
        .busy_o(wBusy[2]), .dump_done_o(wDone[2]), .overflow_o(wOvf[2]), .tx_o(wTx[2]));

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 3; i++) begin
            mOvf[i] = 2'b00;
            for (int ch = 0; ch < NCH; ch++) mCnt[i][ch] = 0;
        end
    endtask

    // One clock of stimulus; every dump issued here is made while the target is idle.
    task automatic applyStimulus(input logic [1:0] ev, input logic en, input logic clr, input logic [2:0] dmp);
        longint unsigned maxV;
        eventI  = ev;
        enb     = en;
        clearI  = clr;
        dumpVec = dmp;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            maxV = (64'd1 << cfgW[i]) - 1;
            if (dmp[i]) for (int ch = 0; ch < NCH; ch++) mSnap[i][ch] = mCnt[i][ch];
            if (clr) begin
                mOvf[i] = 2'b00;
                for (int ch = 0; ch < NCH; ch++) mCnt[i][ch] = 0;
            end else if (en) begin
                for (int ch = 0; ch < NCH; ch++) begin
                    if (ev[ch]) begin
                        if (mCnt[i][ch] == maxV) mOvf[i][ch] = 1'b1;
                        if (cfgSat[i] != 0)
                            mCnt[i][ch] = (mCnt[i][ch] < maxV) ? mCnt[i][ch] + 1 : maxV;
                        else
                            mCnt[i][ch] = (mCnt[i][ch] + 1) % (maxV + 1);
                    end
                end
            end
        end
        #1;
        eventI  = 2'b00;
        enb     = 1'b0;
        clearI  = 1'b0;
        dumpVec = 3'b000;
    endtask

    task automatic captureFrame();
        for (int c = 0; c < NCAP; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                txS[i][c]   = wTx[i];
                busyS[i][c] = wBusy[i];
                doneS[i][c] = wDone[i];
            end
            if (rejectTest != 0 && (c == 10 || c == 50 || c == 200 || c == 240)) dumpVec = 3'b001;
            else dumpVec = 3'b000;
        end
        dumpVec = 3'b000;
    endtask

    task automatic checkFrame(input int i, input string tag);
        logic [7:0] expB [$];
        logic [7:0] chk;
        logic [7:0] got;
        int nb, bl, doneCnt, donePos;
        logic stable, framing;
        nb  = 2 + NCH * cfgW[i] / 8;
        chk = 8'h00;
        expB.push_back(8'hA5);
        for (int ch = 0; ch < NCH; ch++) begin
            for (int b = 0; b < cfgW[i] / 8; b++) begin
                got = 8'((mSnap[i][ch] >> (8 * b)) & 64'hFF);
                expB.push_back(got);
                chk = chk ^ got;
            end
        end
        expB.push_back(chk);
        bl = 0;
        while (bl < NCAP && busyS[i][bl] === 1'b1) bl++;
        checkOutput({tag, "_busyLen"}, 64'(bl), 64'(nb * 10 * BD));
        doneCnt = 0;
        donePos = -1;
        for (int c = 0; c < NCAP; c++) begin
            if (doneS[i][c] === 1'b1) begin
                doneCnt++;
                if (donePos < 0) donePos = c;
            end
        end
        checkOutput({tag, "_doneCount"}, 64'(doneCnt), 64'd1);
        checkOutput({tag, "_donePos"}, 64'(donePos), 64'(nb * 10 * BD));
        stable  = 1'b1;
        framing = 1'b1;
        for (int s = 0; s < nb * 10; s++)
            for (int t = 1; t < BD; t++)
                if (txS[i][s*BD+t] !== txS[i][s*BD]) stable = 1'b0;
        checkOutput({tag, "_bitStable"}, 64'(stable), 64'd1);
        for (int k = 0; k < nb; k++) begin
            if (txS[i][k*10*BD] !== 1'b0 || txS[i][k*10*BD+9*BD] !== 1'b1) framing = 1'b0;
            for (int b = 0; b < 8; b++) got[b] = txS[i][k*10*BD+(b+1)*BD];
            checkOutput($sformatf("%s_i%0d_byte%0d", tag, i, k), 64'(got), 64'(expB[k]));
        end
        checkOutput({tag, "_framing"}, 64'(framing), 64'd1);
    endtask

    task automatic dumpAndCheck(input logic [1:0] ev, input logic en, input logic clr,
                                input logic [2:0] which, input string tag);
        applyStimulus(ev, en, clr, which);
        captureFrame();
        for (int i = 0; i < 3; i++) if (which[i]) checkFrame(i, tag);
    endtask

    task automatic checkOvfAll(input string tag);
        for (int i = 0; i < 3; i++) checkOutput($sformatf("%s_ovf%0d", tag, i), 64'(wOvf[i]), 64'(mOvf[i]));
    endtask

    initial begin
        rst     = 1'b1;
        enb     = 1'b0;
        eventI  = 2'b00;
        clearI  = 1'b0;
        dumpVec = 3'b000;
        modelReset();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checkOutput("reset_tx", 64'(wTx[i]), 64'd1);
            checkOutput("reset_busy", 64'(wBusy[i]), 64'd0);
            checkOutput("reset_done", 64'(wDone[i]), 64'd0);
            checkOutput("reset_ovf", 64'(wOvf[i]), 64'd0);
        end
        rst = 1'b0;

        $display("[TB] basic frame");
        for (int k = 0; k < 5; k++) applyStimulus((k < 3) ? 2'b11 : 2'b01, 1'b1, 1'b0, 3'b000);
        dumpAndCheck(2'b00, 1'b0, 1'b0, 3'b001, "basic");

        $display("[TB] overflow");
        applyStimulus(2'b00, 1'b0, 1'b1, 3'b000);
        for (int k = 0; k < 300; k++) applyStimulus(2'b01, 1'b1, 1'b0, 3'b000);
        checkOvfAll("ovf");
        dumpAndCheck(2'b00, 1'b0, 1'b0, 3'b111, "ovf");
        applyStimulus(2'b00, 1'b0, 1'b1, 3'b000);
        checkOvfAll("ovfClr");
        dumpAndCheck(2'b00, 1'b0, 1'b0, 3'b110, "ovfClr");

        $display("[TB] dump and clear together");
        for (int k = 0; k < 7; k++) applyStimulus(2'b01, 1'b1, 1'b0, 3'b000);
        dumpAndCheck(2'b01, 1'b1, 1'b1, 3'b001, "simul");
        for (int k = 0; k < 3; k++) applyStimulus(2'b01, 1'b1, 1'b0, 3'b000);
        dumpAndCheck(2'b00, 1'b0, 1'b0, 3'b001, "simulAfter");

        $display("[TB] busy rejection");
        rejectTest = 1;
        dumpAndCheck(2'b00, 1'b0, 1'b0, 3'b001, "reject");
        rejectTest = 0;
        checkOutput("reject_secondBusy", 64'(busyS[0][241]), 64'd1);
        checkOutput("reject_secondStart", 64'(txS[0][241]), 64'd0);
        begin
            int n = 0;
            while (wBusy[0] !== 1'b0 && n < 600) begin
                @(negedge clk);
                n++;
            end
            checkOutput("reject_idleTimeout", 64'(wBusy[0]), 64'd0);
        end

        $display("[TB] reset mid-frame");
        for (int k = 0; k < 260; k++) applyStimulus(2'b10, 1'b1, 1'b0, 3'b000);
        checkOvfAll("preRst");
        applyStimulus(2'b00, 1'b0, 1'b0, 3'b001);
        repeat (90) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("midRst_tx", 64'(wTx[0]), 64'd1);
        checkOutput("midRst_busy", 64'(wBusy[0]), 64'd0);
        checkOutput("midRst_ovfSat", 64'(wOvf[1]), 64'd0);
        checkOutput("midRst_ovfWrap", 64'(wOvf[2]), 64'd0);
        modelReset();
        @(negedge clk);
        rst = 1'b0;
        dumpAndCheck(2'b00, 1'b0, 1'b0, 3'b111, "afterRst");

        $display("[TB] enable gating");
        for (int k = 0; k < 20; k++) applyStimulus(2'b11, 1'b0, 1'b0, 3'b000);
        dumpAndCheck(2'b00, 1'b0, 1'b0, 3'b111, "enbOff");

        $display("[TB] random traffic");
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 150; k++)
                applyStimulus(2'($urandom), ($urandom % 4) != 0, ($urandom % 64) == 0, 3'b000);
            checkOvfAll("rand");
            dumpAndCheck(2'b00, 1'b0, 1'b0, 3'b111, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
